seven_seg_scan_controller: RTL

SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

---
 rtl/seven_seg_scan_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - four-digit multiplexed seven-segment scan controller
// Staged load with frame-boundary transfer, leading-zero blanking and anti-ghost blanking.
module seven_seg_scan_controller #(
  parameter int unsigned DWELL = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [15:0] Data_In,
  input  logic        Load,
  input  logic        Blank_En,
  output logic        Load_Ack,
  output logic [3:0]  Anode,
  output logic [6:0]  Seven_Seg,
  output logic [1:0]  Digit_Sel
);

  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic [15:0]     staging_q, staging_d;
  logic [15:0]     displayed_q, displayed_d;
  logic            pending_q, pending_d;
  logic            ack_q, ack_d;
  logic [3:0]      anode_q, anode_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      sel_q, sel_d;
  logic            transfer;
  logic [3:0]      nibble;
  logic            blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0000010;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    staging_d   = staging_q;
    displayed_d = displayed_q;
    pending_d   = pending_q;
    ack_d       = 1'b0;
    anode_d     = 4'b1111;
    seg_d       = 7'b1111111;
    sel_d       = 2'd0;
    transfer    = 1'b0;
    nibble      = 4'h0;
    blank       = 1'b0;

    // run_q distinguishes the first enabled edge, which must land on DIG0/count 0
    if (!Enable) begin
      state_d  = DIG0;
      cnt_d    = '0;
      run_d    = 1'b0;
      transfer = pending_q;
    end else if (!run_q) begin
      state_d = DIG0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
      transfer = pending_q && (state_q == DIG3);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (transfer) begin
      displayed_d = staging_q;
      pending_d   = 1'b0;
      ack_d       = 1'b1;
    end
    // A load on the transfer edge stages the new value after the old one has moved
    if (Load) begin
      staging_d = Data_In;
      pending_d = 1'b1;
    end

    case (state_d)
      DIG0: begin nibble = displayed_q[3:0];   blank = 1'b0; end
      DIG1: begin nibble = displayed_q[7:4];   blank = (displayed_q[15:4] == 12'h000); end
      DIG2: begin nibble = displayed_q[11:8];  blank = (displayed_q[15:8] == 8'h00); end
      default: begin nibble = displayed_q[15:12]; blank = (displayed_q[15:12] == 4'h0); end
    endcase

    if (Enable) begin
      anode_d = ~(4'b0001 << state_d);
      sel_d   = state_d;
      if ((cnt_d != '0) && !(Blank_En && blank)) begin
        seg_d = decode(nibble);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= DIG0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      staging_q   <= 16'h0000;
      displayed_q <= 16'h0000;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      anode_q     <= 4'b1111;
      seg_q       <= 7'b1111111;
      sel_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      staging_q   <= staging_d;
      displayed_q <= displayed_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign Load_Ack  = ack_q;
  assign Anode     = anode_q;
  assign Seven_Seg = seg_q;
  assign Digit_Sel = sel_q;

endmodule
